// File: rtl/i2c_reg_arbiter.sv
// Arbitrates a buffered, non-stallable I2C write stream and a local host port
// onto one single-port register memory.
//   state   | meaning
//   IDLE    | no access issued last cycle; free to issue
//   ISSUE   | write or I2C access issued last cycle; free to issue
//   RD_WAIT | host read in flight; capture mem_rdata, then return to IDLE
module i2c_reg_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int URGENT_LEVEL = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   i2c_addr,
  input  logic [7:0]                   i2c_data,
  input  logic                         i2c_wr_strobe,
  input  logic                         host_req,
  input  logic                         host_we,
  input  logic [7:0]                   host_addr,
  input  logic [7:0]                   host_wdata,
  output logic                         host_gnt,
  output logic [7:0]                   host_rdata,
  output logic                         host_rvalid,
  output logic                         mem_en,
  output logic                         mem_we,
  output logic [7:0]                   mem_addr,
  output logic [7:0]                   mem_wdata,
  input  logic [7:0]                   mem_rdata,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovf,
  input  logic                         ovf_clr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RD_WAIT} state_t;

  state_t           state, state_nx;
  logic [15:0]      fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             fifo_full, fifo_empty, urgent;
  logic             push, pop, drop;
  logic             i2c_cand, host_cand;
  logic             pick_i2c, pick_host, capture;
  logic             rr_favor_i2c;

  assign fifo_empty = (fifo_level == '0);
  assign fifo_full  = (fifo_level == LVL_W'(FIFO_DEPTH));
  assign urgent     = (fifo_level >= LVL_W'(URGENT_LEVEL));
  assign i2c_cand   = !fifo_empty;
  // A request is ignored while its grant is on the wire so it is never taken twice.
  assign host_cand  = host_req && !host_gnt;
  assign pop        = pick_i2c;
  // A full FIFO still accepts a strobe when the head leaves on the same edge.
  assign push       = i2c_wr_strobe && (!fifo_full || pop);
  assign drop       = i2c_wr_strobe && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    pick_i2c  = 1'b0;
    pick_host = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE, ISSUE: begin
        if (i2c_cand && host_cand) begin
          if (urgent || rr_favor_i2c) pick_i2c  = 1'b1;
          else                        pick_host = 1'b1;
        end else if (i2c_cand) begin
          pick_i2c = 1'b1;
        end else if (host_cand) begin
          pick_host = 1'b1;
        end
        if (pick_i2c)       state_nx = ISSUE;
        else if (pick_host) state_nx = host_we ? ISSUE : RD_WAIT;
        else                state_nx = IDLE;
      end
      RD_WAIT: begin
        // First RD_WAIT cycle has the read on the bus; data arrives in the second.
        if (!mem_en) begin
          capture  = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {i2c_addr, i2c_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_level   <= '0;
      ovf          <= 1'b0;
      rr_favor_i2c <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 8'h00;
      mem_wdata    <= 8'h00;
      host_gnt     <= 1'b0;
      host_rvalid  <= 1'b0;
      host_rdata   <= 8'h00;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      fifo_level <= fifo_level + LVL_W'(1);
      else if (pop && !push) fifo_level <= fifo_level - LVL_W'(1);

      // An overflow in the same cycle as a clear leaves the flag set.
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (pick_i2c)       rr_favor_i2c <= 1'b0;
      else if (pick_host) rr_favor_i2c <= 1'b1;

      mem_en   <= pick_i2c || pick_host;
      mem_we   <= pick_i2c || (pick_host && host_we);
      host_gnt <= pick_host;
      if (pick_i2c)       {mem_addr, mem_wdata} <= fifo_mem[rd_ptr];
      else if (pick_host) {mem_addr, mem_wdata} <= {host_addr, host_wdata};

      host_rvalid <= capture;
      if (capture) host_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Bench for i2c_reg_arbiter: memory model plus scoreboard queues of expected
// I2C writes and host read data, with per-scenario tasks.
module tb_i2c_reg_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] i2c_addr, i2c_data;
  logic       i2c_wr_strobe;
  logic       host_req, host_we;
  logic [7:0] host_addr, host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_en, mem_we;
  logic [7:0] mem_addr, mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic [2:0] fifo_level;
  logic       ovf;
  logic       ovf_clr;

  int tests = 0;
  int fails = 0;

  logic [15:0] i2c_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  mem_model [256];

  always #5 clk = ~clk;

  i2c_reg_arbiter #(.FIFO_DEPTH(4), .URGENT_LEVEL(3)) dut (
    .clk(clk), .rst(rst),
    .i2c_addr(i2c_addr), .i2c_data(i2c_data), .i2c_wr_strobe(i2c_wr_strobe),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .fifo_level(fifo_level), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  // Single-port memory: read data valid the cycle after the read enable.
  always @(posedge clk) begin
    if (mem_en === 1'b1) begin
      if (mem_we) mem_model[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_model[mem_addr];
    end
  end

  // Scoreboard: every bus access and every read return is matched against the queues.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_en === 1'b1) begin
        if (host_gnt === 1'b1) begin
          tests++;
          if (mem_we !== host_we || mem_addr !== host_addr || (host_we && mem_wdata !== host_wdata)) begin
            fails++;
            $display("FAIL host_access: got we=%b addr=%h wdata=%h, expected we=%b addr=%h wdata=%h",
                     mem_we, mem_addr, mem_wdata, host_we, host_addr, host_wdata);
          end
          if (mem_we === 1'b0) rd_q.push_back(mem_model[mem_addr]);
        end else begin
          tests++;
          if (i2c_q.size() == 0) begin
            fails++;
            $display("FAIL i2c_unexpected: got write addr=%h data=%h, expected no I2C write", mem_addr, mem_wdata);
          end else begin
            logic [15:0] exp_w;
            exp_w = i2c_q.pop_front();
            if ({mem_we, mem_addr, mem_wdata} !== {1'b1, exp_w}) begin
              fails++;
              $display("FAIL i2c_write: got we=%b addr=%h data=%h, expected we=1 addr=%h data=%h",
                       mem_we, mem_addr, mem_wdata, exp_w[15:8], exp_w[7:0]);
            end
          end
        end
      end
      if (host_rvalid === 1'b1) begin
        tests++;
        if (rd_q.size() == 0) begin
          fails++;
          $display("FAIL rvalid_unexpected: got host_rvalid=1 rdata=%h, expected no read return", host_rdata);
        end else begin
          logic [7:0] exp_r;
          exp_r = rd_q.pop_front();
          if (host_rdata !== exp_r) begin
            fails++;
            $display("FAIL read_data: got %h, expected %h", host_rdata, exp_r);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; i2c_wr_strobe = 1'b0; host_req = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    i2c_q.delete();
    rd_q.delete();
  endtask

  task automatic host_access(input logic we, input logic [7:0] a, input logic [7:0] d);
    bit got;
    got = 1'b0;
    host_we = we; host_addr = a; host_wdata = d; host_req = 1'b1;
    for (int i = 0; i < 20 && !got; i++) begin
      tick();
      if (host_gnt === 1'b1) begin
        got = 1'b1;
        host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    tests++;
    if (!got) begin
      fails++;
      $display("FAIL host_gnt_timeout: got no grant, expected grant within 20 cycles");
    end
    idle(4);
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 40 && (i2c_q.size() != 0 || rd_q.size() != 0); i++) tick();
    tests++;
    if (i2c_q.size() != 0 || rd_q.size() != 0) begin
      fails++;
      $display("FAIL %s_drain: got %0d writes / %0d reads outstanding, expected 0/0", name, i2c_q.size(), rd_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; i2c_wr_strobe = 1'b1; i2c_addr = 8'h01; i2c_data = 8'h02;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h03; host_wdata = 8'h04; ovf_clr = 1'b0;
    idle(3);
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, host_gnt, host_rvalid} !== 4'b0000) begin
      fails++;
      $display("FAIL reset_ctrl: got en/we/gnt/rvalid=%b, expected 0000", {mem_en, mem_we, host_gnt, host_rvalid});
    end
    tests++;
    if ({mem_addr, mem_wdata, host_rdata} !== 24'h0) begin
      fails++;
      $display("FAIL reset_data: got addr/wdata/rdata=%h, expected 000000", {mem_addr, mem_wdata, host_rdata});
    end
    tests++;
    if (fifo_level !== 3'd0 || ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_fifo: got level=%0d ovf=%b, expected level=0 ovf=0", fifo_level, ovf);
    end
    tick();
    rst = 1'b0; i2c_wr_strobe = 1'b0; host_req = 1'b0;
    idle(2);
  endtask

  task automatic test_single_write();
    i2c_addr = 8'h10; i2c_data = 8'hA5; i2c_wr_strobe = 1'b1;
    i2c_q.push_back(16'h10A5);
    tick();
    i2c_wr_strobe = 1'b0;
    @(negedge clk);
    tests++;
    if (fifo_level !== 3'd1 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL write_n1: got level=%0d mem_en=%b, expected level=1 mem_en=0", fifo_level, mem_en);
    end
    tick();
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, host_gnt, mem_addr, mem_wdata} !== {3'b110, 8'h10, 8'hA5}) begin
      fails++;
      $display("FAIL write_n2: got en=%b we=%b gnt=%b addr=%h data=%h, expected en=1 we=1 gnt=0 addr=10 data=a5",
               mem_en, mem_we, host_gnt, mem_addr, mem_wdata);
    end
    tick();
    @(negedge clk);
    tests++;
    if (mem_en !== 1'b0) begin
      fails++;
      $display("FAIL write_n3: got mem_en=%b, expected 0", mem_en);
    end
    tick();
    wait_drain("single_write");
  endtask

  task automatic test_host_read();
    host_access(1'b1, 8'h20, 8'h5C);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    tick();
    host_req = 1'b0;
    @(negedge clk);
    tests++;
    if ({host_gnt, mem_en, mem_we, mem_addr} !== {3'b110, 8'h20}) begin
      fails++;
      $display("FAIL read_gnt: got gnt=%b en=%b we=%b addr=%h, expected gnt=1 en=1 we=0 addr=20",
               host_gnt, mem_en, mem_we, mem_addr);
    end
    tick();
    @(negedge clk);
    tests++;
    if (mem_en !== 1'b0 || host_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL read_gap: got mem_en=%b rvalid=%b, expected 0 0", mem_en, host_rvalid);
    end
    tick();
    @(negedge clk);
    tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h5C) begin
      fails++;
      $display("FAIL read_return: got rvalid=%b rdata=%h, expected rvalid=1 rdata=5c", host_rvalid, host_rdata);
    end
    tick();
    @(negedge clk);
    tests++;
    if (host_rvalid !== 1'b0) begin
      fails++;
      $display("FAIL read_pulse: got rvalid=%b one cycle later, expected 0", host_rvalid);
    end
    tick();
    wait_drain("host_read");
  endtask

  task automatic test_no_forward();
    host_access(1'b1, 8'h30, 8'h11);
    i2c_addr = 8'h30; i2c_data = 8'h99; i2c_wr_strobe = 1'b1;
    i2c_q.push_back(16'h3099);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h30;
    tick();
    i2c_wr_strobe = 1'b0; host_req = 1'b0;
    idle(2);
    @(negedge clk);
    tests++;
    if (host_rvalid !== 1'b1 || host_rdata !== 8'h11) begin
      fails++;
      $display("FAIL no_forward: got rvalid=%b rdata=%h, expected rvalid=1 rdata=11", host_rvalid, host_rdata);
    end
    tick();
    idle(3);
    host_access(1'b0, 8'h30, 8'h00);
    wait_drain("no_forward");
  endtask

  task automatic test_burst();
    logic exp_g;
    do_reset();
    host_we = 1'b1; host_addr = 8'h40; host_wdata = 8'h77;
    for (int k = 0; k <= 10; k++) begin
      host_req = (k < 9);
      i2c_wr_strobe = (k < 5);
      if (k < 5) begin
        i2c_addr = 8'h80 + 8'(k); i2c_data = 8'h50 + 8'(k);
        i2c_q.push_back({i2c_addr, i2c_data});
      end
      @(negedge clk);
      if (k >= 1) begin
        exp_g = (k % 2 == 1);
        tests++;
        if (mem_en !== 1'b1 || host_gnt !== exp_g) begin
          fails++;
          $display("FAIL alternate_c%0d: got mem_en=%b gnt=%b, expected mem_en=1 gnt=%b", k, mem_en, host_gnt, exp_g);
        end
      end
      tick();
    end
    i2c_wr_strobe = 1'b0; host_req = 1'b0;
    @(negedge clk);
    tests++;
    if (fifo_level !== 3'd0 || ovf !== 1'b0 || mem_en !== 1'b0) begin
      fails++;
      $display("FAIL burst_end: got level=%0d ovf=%b mem_en=%b, expected 0 0 0", fifo_level, ovf, mem_en);
    end
    tick();
    wait_drain("burst");
  endtask

  task automatic test_overflow();
    host_access(1'b1, 8'h50, 8'hE1);
    do_reset();
    host_we = 1'b0; host_addr = 8'h50;
    for (int k = 0; k <= 9; k++) begin
      host_req = (k < 9);
      i2c_wr_strobe = (k >= 1 && k <= 7);
      ovf_clr = (k == 6 || k == 7);
      if (k >= 1 && k <= 7) begin
        i2c_addr = 8'h60 + 8'(k - 1); i2c_data = 8'hB0 + 8'(k - 1);
        if (k != 6) i2c_q.push_back({i2c_addr, i2c_data});
      end
      @(negedge clk);
      if (k == 6) begin
        tests++;
        if (fifo_level !== 3'd4 || ovf !== 1'b0) begin
          fails++;
          $display("FAIL ovf_full: got level=%0d ovf=%b, expected level=4 ovf=0", fifo_level, ovf);
        end
      end
      if (k == 7) begin
        tests++;
        if (fifo_level !== 3'd4 || ovf !== 1'b1) begin
          fails++;
          $display("FAIL ovf_set: got level=%0d ovf=%b, expected level=4 ovf=1", fifo_level, ovf);
        end
      end
      if (k == 8) begin
        tests++;
        if (fifo_level !== 3'd4 || ovf !== 1'b0) begin
          fails++;
          $display("FAIL ovf_clear: got level=%0d ovf=%b, expected level=4 ovf=0", fifo_level, ovf);
        end
      end
      if (k == 9) begin
        tests++;
        if (mem_en !== 1'b1 || host_gnt !== 1'b0 || mem_addr !== 8'h62) begin
          fails++;
          $display("FAIL urgent_prio: got en=%b gnt=%b addr=%h, expected en=1 gnt=0 addr=62", mem_en, host_gnt, mem_addr);
        end
      end
      tick();
    end
    i2c_wr_strobe = 1'b0; ovf_clr = 1'b0; host_req = 1'b0;
    wait_drain("overflow");
    tests++;
    if (ovf !== 1'b0 || fifo_level !== 3'd0) begin
      fails++;
      $display("FAIL overflow_end: got ovf=%b level=%0d, expected 0 0", ovf, fifo_level);
    end
  endtask

  task automatic test_reset_rd_wait();
    do_reset();
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h20;
    i2c_addr = 8'h90; i2c_data = 8'h3C; i2c_wr_strobe = 1'b1;
    tick();
    i2c_wr_strobe = 1'b0; host_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    tests++;
    if (host_gnt !== 1'b1 || fifo_level !== 3'd1) begin
      fails++;
      $display("FAIL rdwait_pre: got gnt=%b level=%0d, expected gnt=1 level=1", host_gnt, fifo_level);
    end
    tick();
    rst = 1'b0;
    i2c_q.delete();
    rd_q.delete();
    @(negedge clk);
    tests++;
    if ({mem_en, mem_we, host_gnt, host_rvalid, mem_addr, mem_wdata, host_rdata, fifo_level, ovf} !== 32'h0) begin
      fails++;
      $display("FAIL rdwait_reset: got en=%b we=%b gnt=%b rvalid=%b addr=%h wdata=%h rdata=%h level=%0d ovf=%b, expected all 0",
               mem_en, mem_we, host_gnt, host_rvalid, mem_addr, mem_wdata, host_rdata, fifo_level, ovf);
    end
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      tests++;
      if (host_rvalid !== 1'b0 || mem_en !== 1'b0) begin
        fails++;
        $display("FAIL rdwait_quiet_%0d: got rvalid=%b mem_en=%b, expected 0 0", k, host_rvalid, mem_en);
      end
    end
    tick();
  endtask

  initial begin
    rst = 1'b1; i2c_wr_strobe = 1'b0; i2c_addr = 8'h00; i2c_data = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = 8'h00; host_wdata = 8'h00; ovf_clr = 1'b0;
    test_reset();
    test_single_write();
    test_host_read();
    test_no_forward();
    test_burst();
    test_overflow();
    test_reset_rd_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/i2c_reg_arbiter.md
I2C_REG_ARBITER -- requirements
Module: i2c_reg_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: number of entries in the I2C write buffer (power of two, 2..16).
REQ-002 SHALL have parameter URGENT_LEVEL, default 3: FIFO occupancy at or above which I2C writes take strict priority.
REQ-003 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have ports i2c_addr, i2c_data  input  8 each: register address and write data from the I2C slave.
REQ-006 SHALL have port i2c_wr_strobe  input  1: one-cycle pulse meaning i2c_addr/i2c_data hold a write to commit; it cannot be stalled.
REQ-007 SHALL have port host_req  input  1: local host access request, held until host_gnt.
REQ-008 SHALL have port host_we  input  1: 1 = host write, 0 = host read; valid while host_req=1.
REQ-009 SHALL have ports host_addr, host_wdata  input  8 each: host access address and write data, held while host_req=1.
REQ-010 SHALL have port host_gnt  output  1: one-cycle pulse accepting the held host request.
REQ-011 SHALL have port host_rdata  output  8: read data, valid while host_rvalid=1.
REQ-012 SHALL have port host_rvalid  output  1: one-cycle pulse returning host read data.
REQ-013 SHALL have ports mem_en, mem_we  output  1 each: single-port register memory access enable and write enable.
REQ-014 SHALL have ports mem_addr, mem_wdata  output  8 each: memory address and write data.
REQ-015 SHALL have port mem_rdata  input  8: memory read data, valid the cycle after mem_en=1 with mem_we=0.
REQ-016 SHALL have port fifo_level  output  clog2(FIFO_DEPTH)+1: current I2C buffer occupancy.
REQ-017 SHALL have port ovf  output  1: sticky flag, set when an I2C write was dropped.
REQ-018 SHALL have port ovf_clr  input  1: clears ovf.

Function
REQ-019 SHALL push {i2c_addr,i2c_data} into the FIFO on the edge ending a cycle with i2c_wr_strobe=1; fifo_level rises the next cycle.
REQ-020 SHALL drop a strobe arriving while FIFO is full with no pop that cycle and set ovf; a push coincident with a pop on a full FIFO is accepted without ovf.
REQ-021 SHALL give simultaneous push and pop unchanged fifo_level, with entries leaving in arrival order.
REQ-022 SHALL clear ovf on ovf_clr=1; a same-cycle overflow event wins over ovf_clr (ovf stays 1).
REQ-023 SHALL use an FSM with states IDLE, ISSUE, RD_WAIT; mem_en/mem_we/mem_addr/mem_wdata/host_gnt are registered and high for exactly one cycle per access.
REQ-024 SHALL, in IDLE or ISSUE, issue at the next edge one access chosen from "FIFO non-empty" and "host_req=1 and host_gnt=0"; with no candidate, go to IDLE with mem_en=0.
REQ-025 SHALL give the I2C FIFO strict priority when fifo_level >= URGENT_LEVEL; otherwise, with both pending, grant the requester not granted last (round-robin bit, reset to favour I2C).
REQ-026 SHALL issue an I2C grant as a memory write of the FIFO head, popping it at the same edge; no host_gnt.
REQ-027 SHALL issue a host grant with host_gnt=1 and mem_we=host_we; a host read moves the FSM to RD_WAIT.
REQ-028 SHALL, in RD_WAIT, issue nothing, capture mem_rdata into host_rdata, and pulse host_rvalid the following cycle (2 cycles after the read's mem_en), then return to IDLE.
REQ-029 SHALL ignore host_req in the cycle host_gnt=1 so that one request is never granted twice.
REQ-030 SHALL service a lone strobe at cycle N with mem_en at N+2; a lone host_req first seen at N with host_gnt/mem_en at N+1.
REQ-031 SHALL not forward FIFO contents to reads: a host read of an address with a pending I2C write returns memory contents.

Reset
REQ-032 SHALL, while rst=1, empty the FIFO, clear ovf, force FSM to IDLE, drive mem_en, mem_we, host_gnt, host_rvalid to 0 and mem_addr, mem_wdata, host_rdata to 0x00, and reset round-robin to favour I2C.
REQ-033 SHALL abandon an in-flight host read on reset mid-operation, with no host_rvalid after rst deasserts.

Verification
REQ-034 SHALL cover: strobe addr 0x10 data 0xA5, idle host -> mem_en=1, mem_we=1, mem_addr=0x10, mem_wdata=0xA5 exactly 2 cycles later.
REQ-035 SHALL cover: host read 0x20, memory holds 0x5C -> host_gnt next cycle, host_rvalid=1 with host_rdata=0x5C 2 cycles after gnt, no other access in between.
REQ-036 SHALL cover: 5 strobes in 5 consecutive cycles with host_req held -> I2C gets priority from level 3; no ovf since pops free space; all 5 writes land in order.
REQ-037 SHALL cover: host_req held, FIFO blocked until 4 full, then 5th strobe -> ovf=1, entry dropped; ovf_clr -> ovf=0.
REQ-038 SHALL cover: FIFO level 1 plus continuous host writes -> grants alternate I2C/host every cycle.
REQ-039 SHALL cover: rst asserted in RD_WAIT -> no host_rvalid, fifo_level=0, all outputs at reset values the next cycle.
